// File: rtl/rgmii_rx_deframer.sv
// RGMII receive deframer: turns IDDR-captured RXD/RX_CTL samples into a GMII byte stream,
// decodes in-band link status, optionally strips/validates preamble+SFD, and counts frames.
module rgmii_rx_deframer #(
  parameter bit RISE_LOW_NIBBLE = 1'b1,
  parameter bit AUTO_SPEED      = 1'b1,
  parameter bit STRIP_PREAMBLE  = 1'b1,
  parameter int CNT_W           = 16
) (
  input  logic             phy_rxc,
  input  logic             rst_n,
  input  logic [3:0]       d_rise,
  input  logic [3:0]       d_fall,
  input  logic             c_rise,
  input  logic             c_fall,
  input  logic [1:0]       speed_force,
  output logic [7:0]       gmii_rxd,
  output logic             gmii_rx_dv,
  output logic             gmii_rx_er,
  output logic             gmii_sof,
  output logic             gmii_eof,
  output logic             link_up,
  output logic [1:0]       speed,
  output logic             duplex,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0]       SPD_1G  = 2'b10;
  localparam logic [1:0]       SPD_RST = AUTO_SPEED ? 2'b10 : 2'b00;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

  state_t     state, state_nx;
  logic [2:0] pre_cnt, pre_cnt_nx;
  logic       sof_arm, sof_arm_nx;
  logic       out_vld, out_sof, set_err;

  logic       dv, er, is_1g;
  logic       nib_pend, nib_er;
  logic [3:0] nib_lo;
  logic       byte_vld, byte_er;
  logic [7:0] byte_val;
  logic       end_frame, frame_bad, frame_err;

  logic [3:0] cand_nib;
  logic       cand_vld;
  logic [1:0] st_speed, spd_src;

  assign dv = c_rise;
  assign er = c_rise ^ c_fall;

  // Byte assembly: full byte per dv cycle at 1000M, low-then-high nibble pairs otherwise.
  always_comb begin
    is_1g    = (speed == SPD_1G);
    byte_vld = 1'b0;
    byte_er  = 1'b0;
    byte_val = 8'h00;
    if (dv) begin
      if (is_1g) begin
        byte_vld = 1'b1;
        byte_er  = er;
        byte_val = RISE_LOW_NIBBLE ? {d_fall, d_rise} : {d_rise, d_fall};
      end else if (nib_pend) begin
        byte_vld = 1'b1;
        byte_er  = er | nib_er;
        byte_val = {d_rise, nib_lo};
      end
    end
  end

  // A lone pending nibble at dv fall still counts as an (errored) frame end.
  assign end_frame = !dv && ((state != S_IDLE) || nib_pend);
  assign frame_bad = frame_err || nib_pend || (state != S_DATA);

  always_comb begin
    state_nx   = state;
    pre_cnt_nx = pre_cnt;
    sof_arm_nx = sof_arm;
    out_vld    = 1'b0;
    out_sof    = 1'b0;
    set_err    = 1'b0;
    if (end_frame) begin
      state_nx   = S_IDLE;
      pre_cnt_nx = 3'd0;
      sof_arm_nx = 1'b0;
    end else if (byte_vld) begin
      if (state == S_DATA || (state == S_IDLE && !STRIP_PREAMBLE)) begin
        state_nx   = S_DATA;
        out_vld    = 1'b1;
        out_sof    = (state == S_IDLE) || sof_arm;
        sof_arm_nx = 1'b0;
      end else if (state == S_IDLE || state == S_PRE) begin
        if (byte_val == 8'h55 && pre_cnt != 3'd7) begin
          state_nx   = S_PRE;
          pre_cnt_nx = pre_cnt + 3'd1;
        end else if (byte_val == 8'hD5) begin
          state_nx   = S_DATA;
          pre_cnt_nx = 3'd0;
          sof_arm_nx = 1'b1;
        end else begin
          state_nx = S_DROP;
          set_err  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge phy_rxc or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pre_cnt <= 3'd0;
      sof_arm <= 1'b0;
    end else begin
      state   <= state_nx;
      pre_cnt <= pre_cnt_nx;
      sof_arm <= sof_arm_nx;
    end
  end

  // gmii_rx_dv is a pure strobe with no ready: one byte per asserted cycle, never stalled.
  always_ff @(posedge phy_rxc or negedge rst_n) begin
    if (!rst_n) begin
      nib_pend   <= 1'b0;
      nib_lo     <= 4'h0;
      nib_er     <= 1'b0;
      frame_err  <= 1'b0;
      gmii_rxd   <= 8'h00;
      gmii_rx_dv <= 1'b0;
      gmii_rx_er <= 1'b0;
      gmii_sof   <= 1'b0;
      gmii_eof   <= 1'b0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      if (dv && !is_1g) begin
        nib_pend <= !nib_pend;
        nib_lo   <= d_rise;
        nib_er   <= er;
      end else begin
        nib_pend <= 1'b0;
      end
      if (end_frame)
        frame_err <= 1'b0;
      else if (byte_vld && (byte_er || set_err))
        frame_err <= 1'b1;
      gmii_rx_dv <= out_vld;
      gmii_rx_er <= out_vld && byte_er;
      gmii_sof   <= out_sof;
      gmii_eof   <= end_frame && (state == S_DATA);
      if (out_vld)
        gmii_rxd <= byte_val;
      if (end_frame) begin
        if (frame_bad) begin
          if (err_cnt != '1) err_cnt <= err_cnt + CNT_ONE;
        end else begin
          if (frame_cnt != '1) frame_cnt <= frame_cnt + CNT_ONE;
        end
      end
    end
  end

  // In-band status needs the same nibble in two consecutive idle (ctl=00) samples.
  assign spd_src = AUTO_SPEED ? st_speed : speed_force;

  always_ff @(posedge phy_rxc or negedge rst_n) begin
    if (!rst_n) begin
      cand_nib <= 4'h0;
      cand_vld <= 1'b0;
      link_up  <= 1'b0;
      duplex   <= 1'b0;
      st_speed <= 2'b10;
      speed    <= SPD_RST;
    end else begin
      if (!c_rise && !c_fall) begin
        cand_nib <= d_rise;
        cand_vld <= 1'b1;
        if (cand_vld && cand_nib == d_rise) begin
          link_up <= d_rise[0];
          duplex  <= d_rise[3];
          if (d_rise[2:1] != 2'b11) st_speed <= d_rise[2:1];
        end
      end
      if (state == S_IDLE && !dv && !nib_pend && spd_src != 2'b11)
        speed <= spd_src;
    end
  end

endmodule

// File: tb/tb_rgmii_rx_deframer.sv
// Directed bench for rgmii_rx_deframer: instance a (auto speed, 16-bit counters) and
// instance b (forced speed, swapped nibbles, 3-bit counters) share data lines; sel2 routes RX_CTL.
module tb_rgmii_rx_deframer;

  logic       clk;
  logic       rst_n;
  logic [3:0] d_rise, d_fall;
  logic       c_rise, c_fall;
  logic [1:0] speed_force;
  logic       sel2;

  logic a_cr, a_cf, b_cr, b_cf;
  assign a_cr = c_rise & ~sel2;
  assign a_cf = c_fall & ~sel2;
  assign b_cr = c_rise & sel2;
  assign b_cf = c_fall & sel2;

  logic [7:0]  a_rxd, b_rxd;
  logic        a_dv, a_er, a_sof, a_eof, a_link, a_duplex;
  logic        b_dv, b_er, b_sof, b_eof, b_link, b_duplex;
  logic [1:0]  a_speed, b_speed;
  logic [15:0] a_fcnt, a_ecnt;
  logic [2:0]  b_fcnt, b_ecnt;

  int errors = 0;
  int checks = 0;

  rgmii_rx_deframer #(.RISE_LOW_NIBBLE(1'b1), .AUTO_SPEED(1'b1), .STRIP_PREAMBLE(1'b1), .CNT_W(16)) u_a (
    .phy_rxc(clk), .rst_n(rst_n), .d_rise(d_rise), .d_fall(d_fall),
    .c_rise(a_cr), .c_fall(a_cf), .speed_force(speed_force),
    .gmii_rxd(a_rxd), .gmii_rx_dv(a_dv), .gmii_rx_er(a_er), .gmii_sof(a_sof), .gmii_eof(a_eof),
    .link_up(a_link), .speed(a_speed), .duplex(a_duplex), .frame_cnt(a_fcnt), .err_cnt(a_ecnt)
  );

  rgmii_rx_deframer #(.RISE_LOW_NIBBLE(1'b0), .AUTO_SPEED(1'b0), .STRIP_PREAMBLE(1'b1), .CNT_W(3)) u_b (
    .phy_rxc(clk), .rst_n(rst_n), .d_rise(d_rise), .d_fall(d_fall),
    .c_rise(b_cr), .c_fall(b_cf), .speed_force(speed_force),
    .gmii_rxd(b_rxd), .gmii_rx_dv(b_dv), .gmii_rx_er(b_er), .gmii_sof(b_sof), .gmii_eof(b_eof),
    .link_up(b_link), .speed(b_speed), .duplex(b_duplex), .frame_cnt(b_fcnt), .err_cnt(b_ecnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drivers: inputs change on negedge, outputs sampled 1ns after posedge
  task automatic step(input logic dv, input logic er, input logic [3:0] r, input logic [3:0] f);
    @(negedge clk);
    c_rise = dv;
    c_fall = dv ^ er;
    d_rise = r;
    d_fall = f;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic er, input logic swap);
    if (swap) step(1'b1, er, b[7:4], b[3:0]);
    else      step(1'b1, er, b[3:0], b[7:4]);
  endtask

  task automatic idle(input int n, input logic [3:0] nib);
    repeat (n) step(1'b0, 1'b0, nib, nib);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sel2 = 1'b0; speed_force = 2'b10;
    c_rise = 1'b0; c_fall = 1'b0; d_rise = 4'h0; d_fall = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a_rxd, a_dv, a_er, a_sof, a_eof, a_link, a_duplex} !== 14'h0) begin
      errors++; $display("FAIL reset_a_outputs: got %h want 0", {a_rxd, a_dv, a_er, a_sof, a_eof, a_link, a_duplex});
    end
    checks++;
    if ({a_fcnt, a_ecnt, a_speed} !== {16'h0, 16'h0, 2'b10}) begin
      errors++; $display("FAIL reset_a_cnt_speed: got %h want %h", {a_fcnt, a_ecnt, a_speed}, {16'h0, 16'h0, 2'b10});
    end
    checks++;
    if (b_speed !== 2'b00) begin
      errors++; $display("FAIL reset_b_speed: got %b want 00", b_speed);
    end
    @(negedge clk);
    d_rise = 4'hD; d_fall = 4'hD;
    rst_n = 1'b1;
  endtask

  task automatic test_inband;
    @(posedge clk); #1;
    checks++;
    if (b_speed !== 2'b10) begin
      errors++; $display("FAIL forced_speed_after_reset: got %b want 10", b_speed);
    end
    step(1'b0, 1'b0, 4'hB, 4'hB);
    checks++;
    if ({a_link, a_speed} !== 3'b010) begin
      errors++; $display("FAIL inband_first_b: got %b want 010", {a_link, a_speed});
    end
    step(1'b0, 1'b0, 4'hB, 4'hB);
    checks++;
    if ({a_link, a_duplex} !== 2'b11) begin
      errors++; $display("FAIL inband_second_b: got %b want 11", {a_link, a_duplex});
    end
    step(1'b0, 1'b0, 4'hB, 4'hB);
    checks++;
    if (a_speed !== 2'b01) begin
      errors++; $display("FAIL inband_speed: got %b want 01", a_speed);
    end
  endtask

  task automatic test_100m_frame;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, (i == 15) ? 4'hD : 4'h5, 4'h0);
      checks++;
      if (a_dv !== 1'b0) begin
        errors++; $display("FAIL pre100_no_output: got dv=%b want 0 at nibble %0d", a_dv, i);
      end
    end
    step(1'b1, 1'b0, 4'h3, 4'h0);
    checks++;
    if (a_dv !== 1'b0) begin
      errors++; $display("FAIL nib100_latency: got dv=%b want 0", a_dv);
    end
    step(1'b1, 1'b0, 4'h2, 4'h0);
    checks++;
    if ({a_dv, a_sof, a_er, a_rxd} !== {3'b110, 8'h23}) begin
      errors++; $display("FAIL byte100: got %h want %h", {a_dv, a_sof, a_er, a_rxd}, {3'b110, 8'h23});
    end
    idle(1, 4'hB);
    checks++;
    if ({a_eof, a_dv, a_fcnt} !== {2'b10, 16'd1}) begin
      errors++; $display("FAIL eof100: got %h want %h", {a_eof, a_dv, a_fcnt}, {2'b10, 16'd1});
    end
  endtask

  task automatic test_odd_nibble_10m;
    idle(4, 4'h9);
    checks++;
    if ({a_link, a_speed, a_duplex} !== 4'b1001) begin
      errors++; $display("FAIL inband_10m: got %b want 1001", {a_link, a_speed, a_duplex});
    end
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, (i == 15) ? 4'hD : 4'h5, 4'h0);
    step(1'b1, 1'b0, 4'h1, 4'h0);
    step(1'b1, 1'b0, 4'h2, 4'h0);
    checks++;
    if ({a_dv, a_sof, a_rxd} !== {2'b11, 8'h21}) begin
      errors++; $display("FAIL byte10: got %h want %h", {a_dv, a_sof, a_rxd}, {2'b11, 8'h21});
    end
    step(1'b1, 1'b0, 4'h3, 4'h0);
    checks++;
    if (a_dv !== 1'b0) begin
      errors++; $display("FAIL odd_nibble_no_byte: got dv=%b want 0", a_dv);
    end
    idle(1, 4'h9);
    checks++;
    if ({a_eof, a_ecnt, a_fcnt} !== {1'b1, 16'd1, 16'd1}) begin
      errors++; $display("FAIL odd_nibble_end: got %h want %h", {a_eof, a_ecnt, a_fcnt}, {1'b1, 16'd1, 16'd1});
    end
    idle(4, 4'hD);
    checks++;
    if (a_speed !== 2'b10) begin
      errors++; $display("FAIL inband_1g: got %b want 10", a_speed);
    end
  endtask

  task automatic test_1g_frame;
    for (int i = 0; i < 8; i++) begin
      send_byte((i == 7) ? 8'hD5 : 8'h55, 1'b0, 1'b0);
      checks++;
      if (a_dv !== 1'b0) begin
        errors++; $display("FAIL pre1g_no_output: got dv=%b want 0 at byte %0d", a_dv, i);
      end
    end
    for (int i = 1; i <= 64; i++) begin
      send_byte(8'(i), 1'b0, 1'b0);
      checks++;
      if ({a_dv, a_sof, a_er, a_rxd} !== {1'b1, (i == 1), 1'b0, 8'(i)}) begin
        errors++; $display("FAIL data1g: got %h want %h", {a_dv, a_sof, a_er, a_rxd}, {1'b1, (i == 1), 1'b0, 8'(i)});
      end
    end
    idle(1, 4'hD);
    checks++;
    if ({a_eof, a_dv, a_fcnt} !== {2'b10, 16'd2}) begin
      errors++; $display("FAIL eof1g: got %h want %h", {a_eof, a_dv, a_fcnt}, {2'b10, 16'd2});
    end
    idle(1, 4'hD);
    checks++;
    if (a_eof !== 1'b0) begin
      errors++; $display("FAIL eof1g_pulse: got %b want 0", a_eof);
    end
  endtask

  task automatic test_preamble_error;
    logic [7:0] pre_bytes [4];
    pre_bytes = '{8'h55, 8'h57, 8'hAA, 8'hBB};
    for (int i = 0; i < 4; i++) begin
      send_byte(pre_bytes[i], 1'b0, 1'b0);
      checks++;
      if (a_dv !== 1'b0) begin
        errors++; $display("FAIL bad_pre_no_output: got dv=%b want 0 at byte %0d", a_dv, i);
      end
    end
    idle(1, 4'hD);
    checks++;
    if ({a_eof, a_ecnt, a_fcnt} !== {1'b0, 16'd2, 16'd2}) begin
      errors++; $display("FAIL bad_pre_end: got %h want %h", {a_eof, a_ecnt, a_fcnt}, {1'b0, 16'd2, 16'd2});
    end
    idle(2, 4'hD);
  endtask

  task automatic test_rx_er;
    for (int i = 0; i < 8; i++) send_byte((i == 7) ? 8'hD5 : 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h10 + 8'(i), (i == 10), 1'b0);
      checks++;
      if ({a_dv, a_sof, a_er, a_rxd} !== {1'b1, (i == 0), (i == 10), 8'h10 + 8'(i)}) begin
        errors++; $display("FAIL er_frame_byte: got %h want %h", {a_dv, a_sof, a_er, a_rxd}, {1'b1, (i == 0), (i == 10), 8'h10 + 8'(i)});
      end
    end
    idle(1, 4'hD);
    checks++;
    if ({a_eof, a_ecnt, a_fcnt} !== {1'b1, 16'd3, 16'd2}) begin
      errors++; $display("FAIL er_frame_end: got %h want %h", {a_eof, a_ecnt, a_fcnt}, {1'b1, 16'd3, 16'd2});
    end
    idle(2, 4'hD);
  endtask

  task automatic test_reset_midframe;
    for (int i = 0; i < 8; i++) send_byte((i == 7) ? 8'hD5 : 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_rxd, a_dv, a_er, a_sof, a_eof, a_link, a_duplex, a_fcnt, a_ecnt, a_speed} !== {46'h0, 2'b10}) begin
      errors++; $display("FAIL reset_midframe: got %h want %h", {a_rxd, a_dv, a_er, a_sof, a_eof, a_link, a_duplex, a_fcnt, a_ecnt, a_speed}, {46'h0, 2'b10});
    end
    @(negedge clk);
    c_rise = 1'b0; c_fall = 1'b0; d_rise = 4'hD; d_fall = 4'hD;
    rst_n = 1'b1;
    idle(3, 4'hD);
  endtask

  task automatic test_speed_change_midframe;
    sel2 = 1'b1;
    for (int i = 0; i < 8; i++) send_byte((i == 7) ? 8'hD5 : 8'h55, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) speed_force = 2'b01;
      send_byte(8'hA1 + 8'(i), 1'b0, 1'b1);
      checks++;
      if ({b_dv, b_sof, b_rxd, b_speed} !== {1'b1, (i == 0), 8'hA1 + 8'(i), 2'b10}) begin
        errors++; $display("FAIL swap_byte_speed: got %h want %h", {b_dv, b_sof, b_rxd, b_speed}, {1'b1, (i == 0), 8'hA1 + 8'(i), 2'b10});
      end
    end
    idle(1, 4'h0);
    checks++;
    if ({b_eof, b_speed, b_fcnt} !== {1'b1, 2'b10, 3'd1}) begin
      errors++; $display("FAIL speed_held_to_eof: got %h want %h", {b_eof, b_speed, b_fcnt}, {1'b1, 2'b10, 3'd1});
    end
    idle(1, 4'h0);
    checks++;
    if (b_speed !== 2'b01) begin
      errors++; $display("FAIL speed_after_eof: got %b want 01", b_speed);
    end
    speed_force = 2'b10;
    idle(2, 4'h0);
  endtask

  task automatic test_err_saturation;
    for (int k = 1; k <= 9; k++) begin
      send_byte(8'h00, 1'b0, 1'b1);
      idle(1, 4'h0);
      checks++;
      if (b_ecnt !== ((k > 7) ? 3'd7 : 3'(k))) begin
        errors++; $display("FAIL err_saturate: got %0d want %0d after frame %0d", b_ecnt, (k > 7) ? 7 : k, k);
      end
    end
  endtask

  initial begin
    test_reset;
    test_inband;
    test_100m_frame;
    test_odd_nibble_10m;
    test_1g_frame;
    test_preamble_error;
    test_rx_er;
    test_reset_midframe;
    test_speed_change_midframe;
    test_err_saturation;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
